arith_pipe: RTL and testbench

Parametrised, pipelined successor to the `in_class` three-operand arithmetic block. Takes operand triples `a`, `b`, `c` under a valid/ready handshake. Produces three results:
- a saturating or wrapping sum,
- a fixed-point scaled product,
- a running multiply-accumulate with sticky overflow.

Fixed latency of three accepted cycles, with full backpressure. It sits between an operand source (e.g. a switch/sample front end) and a consumer that may stall.

---
 rtl/arith_pipe_if.sv | 33 +++
 rtl/arith_pipe.sv | 137 +++++++++++++
 tb/tb_arith_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_pipe_if.sv
// Operand/result bus for arith_pipe.
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high. A source holds its payload stable while valid is high and ready is
// low; ready may depend combinationally on the downstream ready.
interface arith_pipe_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [ACC_W-1:0] z;
  logic             ovf;

  // Operand source and result consumer side.
  modport master (
    output in_valid, a, b, c, clr, out_ready,
    input  in_ready, out_valid, x, y, z, ovf
  );

  // Arithmetic pipeline side.
  modport slave (
    input  in_valid, a, b, c, clr, out_ready,
    output in_ready, out_valid, x, y, z, ovf
  );
endinterface

// File: rtl/arith_pipe.sv
// Pipelined three-operand arithmetic: saturating/wrapping sum, scaled product
// and a running multiply-accumulate with sticky overflow. All stages advance
// together when the output slot is empty or being taken, so a stalled consumer
// freezes the whole pipe and nothing is dropped or duplicated.
module arith_pipe #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 0,
  parameter int SAT   = 1,
  parameter int ACC_W = 40
) (
  input logic         clk,
  input logic         reset,
  arith_pipe_if.slave bus
);

  logic                 w_en;

  // S1: captured operands
  logic                 r_s1_v;
  logic [WIDTH-1:0]     r_s1_a;
  logic [WIDTH-1:0]     r_s1_b;
  logic [WIDTH-1:0]     r_s1_c;
  logic                 r_s1_clr;

  // S2: raw sum and product
  logic                 r_s2_v;
  logic [WIDTH:0]       r_s2_sum;
  logic [2*WIDTH-1:0]   r_s2_prod;
  logic                 r_s2_clr;

  // S2 retime register: gives the multiplier a second cycle and sets the
  // three-edge acceptance-to-output latency
  logic                 r_s2r_v;
  logic [WIDTH:0]       r_s2r_sum;
  logic [2*WIDTH-1:0]   r_s2r_prod;
  logic                 r_s2r_clr;

  // S3: results and accumulator
  logic                 r_s3_v;
  logic [WIDTH-1:0]     r_x;
  logic [WIDTH-1:0]     r_y;
  logic [ACC_W-1:0]     r_acc;
  logic                 r_ovf;

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_x;
  logic [WIDTH-1:0]     w_y;
  logic [ACC_W:0]       w_acc_base;
  logic [ACC_W:0]       w_acc_next;

  assign w_en         = !r_s3_v || bus.out_ready;
  assign bus.in_ready = w_en;

  assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_prod = {{WIDTH{1'b0}}, r_s1_a} * {{WIDTH{1'b0}}, r_s1_c};

  assign w_x = ((SAT != 0) && r_s2r_sum[WIDTH]) ? {WIDTH{1'b1}} : r_s2r_sum[WIDTH-1:0];
  assign w_y = WIDTH'(r_s2r_prod >> FRAC);

  // One extra top bit on the adder carries the overflow out of ACC_W bits.
  assign w_acc_base = r_s2r_clr ? '0 : {1'b0, r_acc};
  assign w_acc_next = w_acc_base + {{(ACC_W+1-2*WIDTH){1'b0}}, r_s2r_prod};

  assign bus.out_valid = r_s3_v;
  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.z         = r_acc;
  assign bus.ovf       = r_ovf;

  // S1: capture the operand triple (or a bubble) whenever the pipe advances
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_v   <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_c   <= '0;
      r_s1_clr <= 1'b0;
    end else if (w_en) begin
      r_s1_v   <= bus.in_valid;
      r_s1_a   <= bus.a;
      r_s1_b   <= bus.b;
      r_s1_c   <= bus.c;
      r_s1_clr <= bus.clr;
    end
  end

  // S2: register full-width sum and product
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_v    <= 1'b0;
      r_s2_sum  <= '0;
      r_s2_prod <= '0;
      r_s2_clr  <= 1'b0;
    end else if (w_en) begin
      r_s2_v    <= r_s1_v;
      r_s2_sum  <= w_sum;
      r_s2_prod <= w_prod;
      r_s2_clr  <= r_s1_clr;
    end
  end

  // S2 retime: carry compute results one more cycle toward the output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2r_v    <= 1'b0;
      r_s2r_sum  <= '0;
      r_s2r_prod <= '0;
      r_s2r_clr  <= 1'b0;
    end else if (w_en) begin
      r_s2r_v    <= r_s2_v;
      r_s2r_sum  <= r_s2_sum;
      r_s2r_prod <= r_s2_prod;
      r_s2r_clr  <= r_s2_clr;
    end
  end

  // S3: format x/y and update accumulator and sticky overflow on valid entry only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s3_v <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
    end else if (w_en) begin
      r_s3_v <= r_s2r_v;
      if (r_s2r_v) begin
        r_x   <= w_x;
        r_y   <= w_y;
        r_acc <= w_acc_next[ACC_W-1:0];
        r_ovf <= r_s2r_clr ? w_acc_next[ACC_W] : (r_ovf | w_acc_next[ACC_W]);
      end
    end
  end

endmodule

// File: tb/tb_arith_pipe.sv
// Bench for arith_pipe: two instances with different parameter sets share the
// same stimulus; each is scored against an arithmetic reference model.
module tb_arith_pipe;

  localparam int A_FRAC = 0;
  localparam int A_SAT  = 1;
  localparam int A_ACCW = 32;
  localparam int B_FRAC = 8;
  localparam int B_SAT  = 0;
  localparam int B_ACCW = 40;
  localparam int W      = 73;  // {ovf, z[39:0], y[15:0], x[15:0]}

  logic clk;
  logic reset;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]    exp_q_a[$];
  logic [W-1:0]    exp_q_b[$];
  longint unsigned m_acc[2];
  bit              m_ovf[2];

  logic [15:0] burst_a[$];
  logic [15:0] burst_b[$];
  logic [15:0] burst_c[$];
  logic        burst_clr[$];
  logic [15:0] obs_x[$];
  logic [63:0] obs_z[$];
  logic        obs_ovf[$];
  int          obs_cyc[$];

  arith_pipe_if #(.WIDTH(16), .ACC_W(A_ACCW)) ia ();
  arith_pipe_if #(.WIDTH(16), .ACC_W(B_ACCW)) ib ();

  arith_pipe #(.WIDTH(16), .FRAC(A_FRAC), .SAT(A_SAT), .ACC_W(A_ACCW)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  arith_pipe #(.WIDTH(16), .FRAC(B_FRAC), .SAT(B_SAT), .ACC_W(B_ACCW)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: acceptance-order arithmetic straight from the rules
  task automatic model_push(input int w, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic clr);
    longint unsigned la, lb, lc, sum, prod, base, accf, modv;
    logic [15:0] ex, ey;
    logic [39:0] ez;
    logic        eo, carry;
    int          frac, accw;
    bit          sat;
    frac = (w == 0) ? A_FRAC : B_FRAC;
    sat  = (w == 0) ? (A_SAT != 0) : (B_SAT != 0);
    accw = (w == 0) ? A_ACCW : B_ACCW;
    la = 64'(a); lb = 64'(b); lc = 64'(c);
    sum  = la + lb;
    ex   = (sat && sum > 64'hFFFF) ? 16'hFFFF : 16'(sum);
    prod = la * lc;
    ey   = 16'(prod >> frac);
    modv = 64'd1 << accw;
    base = clr ? 64'd0 : m_acc[w];
    accf = base + prod;
    carry = (accf >= modv);
    m_acc[w] = accf % modv;
    eo = clr ? carry : (m_ovf[w] | carry);
    m_ovf[w] = eo;
    ez = 40'(m_acc[w]);
    if (w == 0) exp_q_a.push_back({eo, ez, ey, ex});
    else        exp_q_b.push_back({eo, ez, ey, ex});
  endtask

  task automatic score(input int w, input logic [15:0] x, input logic [15:0] y,
                       input logic [39:0] z, input logic ovf);
    logic [W-1:0] e;
    string nm;
    nm = (w == 0) ? "a" : "b";
    if ((w == 0 && exp_q_a.size() == 0) || (w == 1 && exp_q_b.size() == 0)) begin
      chk({nm, "_unexpected_output"}, 64'd1, 64'd0);
    end else begin
      e = (w == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
      chk({nm, "_x"},   64'(x),   64'(e[15:0]));
      chk({nm, "_y"},   64'(y),   64'(e[31:16]));
      chk({nm, "_z"},   64'(z),   64'(e[71:32]));
      chk({nm, "_ovf"}, 64'(ovf), 64'(e[72]));
    end
  endtask

  // scoreboard: observe both handshakes mid-cycle, before the transferring edge
  always @(negedge clk) begin
    if (reset) begin
      if (ia.out_valid && ia.out_ready) score(0, ia.x, ia.y, 40'(ia.z), ia.ovf);
      if (ib.out_valid && ib.out_ready) score(1, ib.x, ib.y, ib.z, ib.ovf);
      if (ia.in_valid && ia.in_ready) model_push(0, ia.a, ia.b, ia.c, ia.clr);
      if (ib.in_valid && ib.in_ready) model_push(1, ib.a, ib.b, ib.c, ib.clr);
    end
  end

  // driver tasks
  task automatic set_in(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic clr);
    ia.in_valid = v; ia.a = a; ia.b = b; ia.c = c; ia.clr = clr;
    ib.in_valid = v; ib.a = a; ib.b = b; ib.c = c; ib.clr = clr;
  endtask

  task automatic set_ordy(input logic r);
    ia.out_ready = r;
    ib.out_ready = r;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic clr);
    burst_a.push_back(a); burst_b.push_back(b); burst_c.push_back(c); burst_clr.push_back(clr);
  endtask

  // one triple into an idle pipe; returns at the mid-cycle where its result is shown
  task automatic send_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic clr);
    int lat;
    @(posedge clk); #1;
    set_ordy(1'b1);
    set_in(1'b1, a, b, c, clr);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(ia.in_ready), 64'd1);
    @(posedge clk); #1;
    set_in(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    lat = 0;
    @(negedge clk);
    while (!ia.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd3);
  endtask

  // stream the loaded triples back to back, optionally holding out_ready low
  // for 'hold' cycles from the first visible result
  task automatic run_burst(input int hold);
    int n, sent, got, cyc, hold_left;
    bit holding, snapped;
    logic [15:0] sx;
    logic [63:0] sz;
    n = burst_a.size();
    sent = 0; got = 0; cyc = 0; hold_left = hold; snapped = 0;
    sx = '0; sz = '0;
    obs_x.delete(); obs_z.delete(); obs_ovf.delete(); obs_cyc.delete();
    @(posedge clk); #1;
    while (got < n && cyc < 100) begin
      if (sent < n) set_in(1'b1, burst_a[sent], burst_b[sent], burst_c[sent], burst_clr[sent]);
      else          set_in(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
      holding = (hold_left > 0) && ia.out_valid;
      if (holding) begin
        if (!snapped) begin
          sx = ia.x;
          sz = 64'(ia.z);
          snapped = 1;
        end
        hold_left--;
      end
      set_ordy(!holding);
      @(negedge clk);
      if (holding) begin
        chk("bp_in_ready", 64'(ia.in_ready), 64'd0);
        chk("bp_out_valid", 64'(ia.out_valid), 64'd1);
        chk("bp_x_stable", 64'(ia.x), 64'(sx));
        chk("bp_z_stable", 64'(ia.z), sz);
      end
      if (ia.in_valid && ia.in_ready) sent++;
      if (ia.out_valid && ia.out_ready) begin
        obs_x.push_back(ia.x);
        obs_z.push_back(64'(ia.z));
        obs_ovf.push_back(ia.ovf);
        obs_cyc.push_back(cyc);
        got++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    set_in(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    set_ordy(1'b1);
    chk("burst_result_count", 64'(got), 64'(n));
    burst_a.delete(); burst_b.delete(); burst_c.delete(); burst_clr.delete();
  endtask

  initial begin
    bit took;
    m_acc[0] = 0; m_acc[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    reset = 1'b0;
    set_in(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    set_ordy(1'b1);

    // reset state
    #2;
    chk("rst_out_valid_a", 64'(ia.out_valid), 64'd0);
    chk("rst_out_valid_b", 64'(ib.out_valid), 64'd0);
    chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
    chk("rst_x", 64'(ia.x), 64'd0);
    chk("rst_y", 64'(ia.y), 64'd0);
    chk("rst_z", 64'(ia.z), 64'd0);
    chk("rst_ovf", 64'(ia.ovf), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // sum and scaled product, single transactions
    send_single("sum_plain", 16'h1234, 16'h0FFF, 16'h0000, 1'b1);
    chk("sum_plain_x", 64'(ia.x), 64'h2233);
    send_single("sum_carry", 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    chk("sum_sat_x", 64'(ia.x), 64'hFFFF);
    chk("sum_wrap_x", 64'(ib.x), 64'h0000);
    send_single("prod_frac8", 16'h0300, 16'h0000, 16'h0200, 1'b0);
    chk("prod_frac8_y", 64'(ib.y), 64'h0600);
    send_single("prod_frac0", 16'h0100, 16'h0000, 16'h0100, 1'b0);
    chk("prod_frac0_y", 64'(ia.y), 64'h0000);

    // accumulate with clr, back to back
    load(16'd2, 16'd0, 16'd3, 1'b1);
    load(16'd4, 16'd0, 16'd5, 1'b0);
    load(16'd6, 16'd0, 16'd7, 1'b0);
    load(16'd1, 16'd0, 16'd1, 1'b1);
    run_burst(0);
    if (obs_z.size() == 4) begin
      chk("acc_z0", obs_z[0], 64'd6);
      chk("acc_z1", obs_z[1], 64'd26);
      chk("acc_z2", obs_z[2], 64'd68);
      chk("acc_z3", obs_z[3], 64'd1);
      chk("acc_consecutive", 64'(obs_cyc[3] - obs_cyc[0]), 64'd3);
    end

    // overflow and sticky flag
    load(16'hFFFF, 16'd0, 16'hFFFF, 1'b1);
    load(16'hFFFF, 16'd0, 16'hFFFF, 1'b0);
    run_burst(0);
    if (obs_z.size() == 2) begin
      chk("ovf_z0", obs_z[0], 64'hFFFE0001);
      chk("ovf_z1", obs_z[1], 64'hFFFC0002);
      chk("ovf_f0", 64'(obs_ovf[0]), 64'd0);
      chk("ovf_f1", 64'(obs_ovf[1]), 64'd1);
    end
    repeat (3) @(negedge clk);
    chk("ovf_sticky_bubble", 64'(ia.ovf), 64'd1);
    load(16'd1, 16'd0, 16'd1, 1'b1);
    run_burst(0);
    if (obs_z.size() == 1) begin
      chk("ovf_clr_flag", 64'(obs_ovf[0]), 64'd0);
      chk("ovf_clr_z", obs_z[0], 64'd1);
    end

    // backpressure: 8 triples with a 5-cycle consumer stall
    for (int i = 1; i <= 8; i++) load(16'(i), 16'd0, 16'($urandom_range(0, 65535)), 1'b0);
    run_burst(5);
    if (obs_x.size() == 8) begin
      for (int i = 0; i < 8; i++) chk($sformatf("bp_order_%0d", i), 64'(obs_x[i]), 64'(i + 1));
    end

    // randomized traffic with random consumer stalls
    took = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (took) begin
        if ($urandom_range(0, 3) != 0)
          set_in(1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 16'($urandom_range(0, 65535)), ($urandom_range(0, 7) == 0));
        else
          set_in(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
      end
      set_ordy($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = !ia.in_valid || ia.in_ready;
    end
    @(posedge clk); #1;
    set_in(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    set_ordy(1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("drain_a", 64'(exp_q_a.size()), 64'd0);
    chk("drain_b", 64'(exp_q_b.size()), 64'd0);

    // reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 16'($urandom_range(1, 65535)), 16'd0, 16'($urandom_range(1, 65535)), 1'b0);
      @(posedge clk); #1;
    end
    set_in(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    reset = 1'b0;
    exp_q_a.delete(); exp_q_b.delete();
    m_acc[0] = 0; m_acc[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    #1;
    chk("midrst_out_valid", 64'(ia.out_valid), 64'd0);
    chk("midrst_z", 64'(ia.z), 64'd0);
    chk("midrst_ovf", 64'(ia.ovf), 64'd0);
    chk("midrst_in_ready", 64'(ia.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    load(16'd3, 16'd0, 16'd3, 1'b0);
    run_burst(0);
    if (obs_z.size() == 1) chk("midrst_first_z", obs_z[0], 64'd9);
    repeat (6) @(negedge clk);
    chk("midrst_no_extra", 64'(ia.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
